key_load_ctrl: RTL and testbench

- Sequencer that loads a complete round-key schedule into the round-key store ahead of the encryption pipelines.
- Accepts round keys one at a time from the key expansion unit over a valid/ready handshake.
- Drives the store's load, round_number and key inputs, and holds off reloading while encryption blocks are in flight.
- Flags when the whole schedule is resident, so the pipelines can start issuing count1/count2/count3 lookups.

---
 rtl/key_load_ctrl.sv | 131 +++++++++++++
 tb/tb_key_load_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/key_load_ctrl.sv
// Round-key schedule loader: accepts NUM_ROUNDS+1 keys over valid/ready and writes them
// into the round-key store, holding off while encryption blocks are still in flight.
module key_load_ctrl #(
    parameter int unsigned NUM_ROUNDS = 14,
    parameter int unsigned RN_W       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            busy_in,
    input  logic            key_valid,
    input  logic [127:0]    key_in,
    output logic            key_ready,
    output logic            ks_load,
    output logic [RN_W-1:0] ks_round_number,
    output logic [127:0]    ks_key,
    output logic            schedule_valid,
    output logic            done
);

    typedef enum logic [1:0] {StIdle, StDrain, StLoad, StDone} state_e;

    localparam logic [RN_W-1:0] LastIdx = RN_W'(NUM_ROUNDS);

    state_e            state_q, state_d;
    logic [RN_W-1:0]   idx_q, idx_d;
    logic              ks_load_d;
    logic [RN_W-1:0]   ks_rn_d;
    logic [127:0]      ks_key_d;
    logic              sv_d;
    logic              done_d;
    logic              xfer;

    assign xfer = key_valid & key_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over the final transfer so an aborted load never flags done
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = busy_in ? StDrain : StLoad;
                end
            end
            StDrain: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (!busy_in) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (xfer && (idx_q == LastIdx)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic
    always_comb begin
        key_ready = (state_q == StLoad);
    end

    // Registered store-side datapath
    always_comb begin
        idx_d     = idx_q;
        ks_load_d = 1'b0;
        ks_rn_d   = ks_round_number;
        ks_key_d  = ks_key;
        sv_d      = schedule_valid;
        done_d    = 1'b0;

        if ((state_q == StIdle) && start) begin
            idx_d = '0;
            sv_d  = 1'b0;
        end

        if (xfer) begin
            ks_load_d = 1'b1;
            ks_rn_d   = idx_q;
            ks_key_d  = key_in;
            if (idx_q != LastIdx) begin
                idx_d = idx_q + 1'b1;
            end
        end

        // The store captures the final key on the same edge that leaves DONE
        if (state_q == StDone) begin
            sv_d   = 1'b1;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q           <= '0;
            ks_load         <= 1'b0;
            ks_round_number <= '0;
            ks_key          <= '0;
            schedule_valid  <= 1'b0;
            done            <= 1'b0;
        end else begin
            idx_q           <= idx_d;
            ks_load         <= ks_load_d;
            ks_round_number <= ks_rn_d;
            ks_key          <= ks_key_d;
            schedule_valid  <= sv_d;
            done            <= done_d;
        end
    end

endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed, table-driven bench for key_load_ctrl plus a hand-written async-reset sequence.
module tb_key_load_ctrl;

    logic         clk;
    logic         rst;
    logic         start;
    logic         abort;
    logic         busy_in;
    logic         key_valid;
    logic [127:0] key_in;
    logic         key_ready;
    logic         ks_load;
    logic [3:0]   ks_round_number;
    logic [127:0] ks_key;
    logic         schedule_valid;
    logic         done;

    key_load_ctrl #(
        .NUM_ROUNDS(14),
        .RN_W      (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .busy_in        (busy_in),
        .key_valid      (key_valid),
        .key_in         (key_in),
        .key_ready      (key_ready),
        .ks_load        (ks_load),
        .ks_round_number(ks_round_number),
        .ks_key         (ks_key),
        .schedule_valid (schedule_valid),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         start;
        logic         abort;
        logic         busy;
        logic         kv;
        logic [127:0] key;
        logic         e_rdy;
        logic         e_load;
        logic [3:0]   e_rn;
        logic [127:0] e_key;
        logic         e_sv;
        logic         e_done;
        string        name;
    } vec_t;

    vec_t vecs[$];
    int   n_applied = 0;
    int   n_fail    = 0;

    function automatic logic [127:0] kval(input int t, input int i);
        return {32'(t), 64'h0, 32'(i)};
    endfunction

    task automatic push(input logic s, input logic a, input logic b, input logic kv,
                        input logic [127:0] k, input logic rdy, input logic ld,
                        input int rn, input logic [127:0] ek, input logic sv,
                        input logic dn, input string nm);
        vec_t v;
        v.start = s;   v.abort = a;   v.busy = b;    v.kv = kv;   v.key = k;
        v.e_rdy = rdy; v.e_load = ld; v.e_rn = 4'(rn); v.e_key = ek;
        v.e_sv = sv;   v.e_done = dn; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic rdy, input logic ld, input logic [3:0] rn,
                         input logic [127:0] ek, input logic sv, input logic dn);
        n_applied++;
        if (key_ready !== rdy || ks_load !== ld || ks_round_number !== rn || ks_key !== ek ||
            schedule_valid !== sv || done !== dn) begin
            n_fail++;
            $display("FAIL %s: got rdy=%b ld=%b rn=%0d key=%h sv=%b done=%b, want rdy=%b ld=%b rn=%0d key=%h sv=%b done=%b",
                     nm, key_ready, ks_load, ks_round_number, ks_key, schedule_valid, done,
                     rdy, ld, rn, ek, sv, dn);
        end
    endtask

    task automatic run_from(input int first);
        for (int n = first; n < vecs.size(); n++) begin
            start     = vecs[n].start;
            abort     = vecs[n].abort;
            busy_in   = vecs[n].busy;
            key_valid = vecs[n].kv;
            key_in    = vecs[n].key;
            @(posedge clk);
            #1;
            check(vecs[n].name, vecs[n].e_rdy, vecs[n].e_load, vecs[n].e_rn, vecs[n].e_key,
                  vecs[n].e_sv, vecs[n].e_done);
        end
    endtask

    initial begin
        int mark;
        rst = 1'b1; start = 1'b0; abort = 1'b0; busy_in = 1'b0; key_valid = 1'b0; key_in = '0;
        #1;
        check("reset_async", 1'b0, 1'b0, 4'd0, 128'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_held", 1'b0, 1'b0, 4'd0, 128'h0, 1'b0, 1'b0);

        // Full back-to-back load
        push(1, 0, 0, 1, kval(0, 0), 1, 0, 0, 128'h0, 0, 0, "t2_start");
        for (int i = 0; i < 15; i++)
            push(0, 0, 0, 1, kval(0, i), i < 14, 1, i, kval(0, i), 0, 0, "t2_xfer");
        push(0, 0, 0, 1, kval(0, 99), 0, 0, 14, kval(0, 14), 1, 1, "t2_done");
        push(0, 0, 0, 1, kval(0, 98), 0, 0, 14, kval(0, 14), 1, 0, "t2_idle_kv");

        // Toggled key_valid, start pulsed during LOAD and DONE
        push(1, 0, 0, 0, kval(3, 77), 1, 0, 14, kval(0, 14), 0, 0, "t3_start");
        for (int i = 0; i < 15; i++) begin
            push(0, 0, 0, 1, kval(3, i), i < 14, 1, i, kval(3, i), 0, 0, "t3_xfer");
            if (i < 14)
                push(1, 0, 0, 0, kval(3, 77), 1, 0, i, kval(3, i), 0, 0, "t3_gap");
        end
        push(1, 0, 0, 0, kval(3, 77), 0, 0, 14, kval(3, 14), 1, 1, "t3_done");
        push(0, 0, 0, 1, kval(3, 78), 0, 0, 14, kval(3, 14), 1, 0, "t3_hold");

        // Start while busy: drain for 10 cycles, then load with busy toggling
        push(1, 0, 1, 1, kval(4, 0), 0, 0, 14, kval(3, 14), 0, 0, "t4_start");
        for (int i = 0; i < 9; i++)
            push(0, 0, 1, 1, kval(4, 0), 0, 0, 14, kval(3, 14), 0, 0, "t4_drain");
        push(0, 0, 0, 1, kval(4, 0), 1, 0, 14, kval(3, 14), 0, 0, "t4_enter");
        for (int i = 0; i < 15; i++)
            push(0, 0, i[0], 1, kval(4, i), i < 14, 1, i, kval(4, i), 0, 0, "t4_xfer");
        push(0, 0, 0, 0, kval(4, 0), 0, 0, 14, kval(4, 14), 1, 1, "t4_done");

        // Abort after 7 transfers
        push(1, 0, 0, 1, kval(5, 0), 1, 0, 14, kval(4, 14), 0, 0, "t5_start");
        for (int i = 0; i < 7; i++)
            push(0, 0, 0, 1, kval(5, i), 1, 1, i, kval(5, i), 0, 0, "t5_xfer");
        push(0, 1, 0, 0, kval(5, 7), 0, 0, 6, kval(5, 6), 0, 0, "t5_abort");
        push(0, 0, 0, 1, kval(5, 7), 0, 0, 6, kval(5, 6), 0, 0, "t5_idle");
        // Abort from DRAIN
        push(1, 0, 1, 0, kval(5, 8), 0, 0, 6, kval(5, 6), 0, 0, "t5b_drain");
        push(0, 1, 1, 1, kval(5, 8), 0, 0, 6, kval(5, 6), 0, 0, "t5b_abort");
        push(0, 0, 0, 1, kval(5, 8), 0, 0, 6, kval(5, 6), 0, 0, "t5b_idle");
        // Abort coinciding with a transfer: the write still lands
        push(1, 0, 0, 1, kval(6, 0), 1, 0, 6, kval(5, 6), 0, 0, "t5c_start");
        push(0, 1, 0, 1, kval(6, 0), 0, 1, 0, kval(6, 0), 0, 0, "t5c_abort_xfer");
        push(0, 0, 0, 1, kval(6, 1), 0, 0, 0, kval(6, 0), 0, 0, "t5c_idle");

        // Get to LOAD with 5 transfers done, ahead of the async reset
        push(1, 0, 0, 1, kval(7, 0), 1, 0, 0, kval(6, 0), 0, 0, "t1_start");
        for (int i = 0; i < 5; i++)
            push(0, 0, 0, 1, kval(7, i), 1, 1, i, kval(7, i), 0, 0, "t1_xfer");
        run_from(0);

        #2;
        rst = 1'b1;
        #1;
        check("t1_async_rst", 1'b0, 1'b0, 4'd0, 128'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t1_rst_held", 1'b0, 1'b0, 4'd0, 128'h0, 1'b0, 1'b0);

        mark = vecs.size();
        push(0, 0, 0, 1, kval(8, 9), 0, 0, 0, 128'h0, 0, 0, "t1_idle");
        push(1, 0, 0, 1, kval(8, 0), 1, 0, 0, 128'h0, 0, 0, "t1_restart");
        push(0, 0, 0, 1, kval(8, 0), 1, 1, 0, kval(8, 0), 0, 0, "t1_reload0");
        push(0, 0, 0, 1, kval(8, 1), 1, 1, 1, kval(8, 1), 0, 0, "t1_reload1");
        run_from(mark);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end

endmodule
